// File: rtl/mem_arbiter_if.sv
// ============================================================================
//  mem_arbiter_if : CPU, display and memory buses around the memory arbiter
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter : CPU-priority arbiter for the shared CHIP-8 memory with a
//                starvation guard for the display scanout reader
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DISP = 2'd2
    } owner_t;

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0] C_FB_PAGE      = 4'h1;

    owner_t      r_owner;
    owner_t      w_owner_nxt;
    logic [3:0]  r_starve;
    logic [3:0]  w_starve_nxt;
    logic        w_force_disp;
    logic        w_cpu_gnt;
    logic        w_disp_gnt;
    logic        w_unused;

    assign w_unused = ^bus.disp_addr[ADDR_W-1:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= OWN_NONE;
            r_starve <= 4'd0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        w_owner_nxt     = OWN_NONE;
        w_starve_nxt    = r_starve;
        bus.mem_addr    = '0;
        bus.mem_we      = 1'b0;
        bus.mem_wdata   = '0;
        bus.cpu_rvalid  = 1'b0;
        bus.cpu_rdata   = '0;
        bus.disp_rvalid = 1'b0;
        bus.disp_rdata  = '0;

        // Grants are gated by rst_n so they drop the instant reset asserts
        w_force_disp = (r_starve == C_STARVE_LIMIT);
        w_disp_gnt   = rst_n & bus.disp_req & (~bus.cpu_req | w_force_disp);
        w_cpu_gnt    = rst_n & bus.cpu_req & ~w_disp_gnt;
        bus.cpu_gnt  = w_cpu_gnt;
        bus.disp_gnt = w_disp_gnt;

        if (w_cpu_gnt) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_we    = bus.cpu_we;
            bus.mem_wdata = bus.cpu_wdata;
            if (!bus.cpu_we) begin
                w_owner_nxt = OWN_CPU;
            end
        end else if (w_disp_gnt) begin
            // Display reads always land in the framebuffer page
            bus.mem_addr = ADDR_W'({C_FB_PAGE, bus.disp_addr[7:0]});
            w_owner_nxt  = OWN_DISP;
        end

        if (!bus.disp_req || w_disp_gnt) begin
            w_starve_nxt = 4'd0;
        end else if (w_cpu_gnt) begin
            w_starve_nxt = r_starve + 4'd1;
        end

        case (r_owner)
            OWN_CPU: begin
                bus.cpu_rvalid = 1'b1;
                bus.cpu_rdata  = bus.mem_rdata;
            end
            OWN_DISP: begin
                bus.disp_rvalid = 1'b1;
                bus.disp_rdata  = bus.mem_rdata;
            end
            default: begin
                bus.cpu_rvalid  = 1'b0;
                bus.disp_rvalid = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  tb_mem_arbiter : directed stimulus against a bench-side reference model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 8;
    localparam int STARVE_LIMIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    function automatic logic [7:0] pat(int a);
        if (a == 'h200) return 8'h42;
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Synchronous single-port memory
    logic [7:0] mem [4096];
    bit         mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
            mem_ready <= 1'b1;
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who wins, what the memory sees, what comes back
    logic [7:0] ref_mem [4096];
    int         waited;
    int         pend_who;
    logic [7:0] pend_data;

    initial begin : model
        bit         e_cg, e_dg;
        logic [11:0] e_addr, s_cpu_addr, s_disp_addr;
        logic        e_we, s_cpu_we;
        logic [7:0]  e_wdata, s_cpu_wdata;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        waited = 0;
        pend_who = 0;
        pend_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_who = 0;
                waited   = 0;
            end
            e_dg = rst_n && bus.disp_req && (!bus.cpu_req || waited >= STARVE_LIMIT);
            e_cg = rst_n && bus.cpu_req && !e_dg;
            s_cpu_addr  = bus.cpu_addr;
            s_cpu_we    = bus.cpu_we;
            s_cpu_wdata = bus.cpu_wdata;
            s_disp_addr = {4'h1, bus.disp_addr[7:0]};
            e_addr = e_cg ? s_cpu_addr : (e_dg ? s_disp_addr : 12'h000);
            e_we   = e_cg && s_cpu_we;
            e_wdata = e_cg ? s_cpu_wdata : 8'h00;
            chk("model_cpu_gnt",     32'(bus.cpu_gnt),     32'(e_cg));
            chk("model_disp_gnt",    32'(bus.disp_gnt),    32'(e_dg));
            chk("model_mem_addr",    32'(bus.mem_addr),    32'(e_addr));
            chk("model_mem_we",      32'(bus.mem_we),      32'(e_we));
            chk("model_mem_wdata",   32'(bus.mem_wdata),   32'(e_wdata));
            chk("model_cpu_rvalid",  32'(bus.cpu_rvalid),  32'(pend_who == 1));
            chk("model_disp_rvalid", 32'(bus.disp_rvalid), 32'(pend_who == 2));
            chk("model_cpu_rdata",   32'(bus.cpu_rdata),   32'(pend_who == 1 ? pend_data : 8'h00));
            chk("model_disp_rdata",  32'(bus.disp_rdata),  32'(pend_who == 2 ? pend_data : 8'h00));
            @(posedge clk);
            if (!rst_n) begin
                pend_who = 0;
                waited   = 0;
            end else begin
                pend_who = 0;
                if (e_cg && s_cpu_we) begin
                    ref_mem[s_cpu_addr] = s_cpu_wdata;
                end else if (e_cg) begin
                    pend_who  = 1;
                    pend_data = ref_mem[s_cpu_addr];
                end else if (e_dg) begin
                    pend_who  = 2;
                    pend_data = ref_mem[s_disp_addr];
                end
                if (!bus.disp_req || e_dg) waited = 0;
                else if (e_cg) waited = waited + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int n, output string seq);
        seq = "";
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            seq = {seq, bus.disp_gnt ? "D" : (bus.cpu_gnt ? "C" : "-")};
            tick();
        end
    endtask

    task automatic chk_seq(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%s expected=%s", name, act, exp);
        end
    endtask

    initial begin : stim
        string seq;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        chk("reset_rvalid", 32'({bus.cpu_rvalid, bus.disp_rvalid}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // CPU read with display idle
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
        @(negedge clk);
        chk("t1_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        chk("t1_disp_gnt", 32'(bus.disp_gnt), 32'd0);
        tick();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("t1_cpu_rdata", 32'(bus.cpu_rdata), 32'h42);
        tick();

        // Both held: starvation guard every fifth slot
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h300;
        bus.disp_req = 1'b1; bus.disp_addr = 12'h120;
        record(10, seq);
        chk_seq("t2_grant_seq", seq, "CCCCDCCCCD");
        bus.cpu_req = 1'b0; bus.disp_req = 1'b0;
        tick();

        // Display-only read with out-of-range address
        bus.disp_req = 1'b1; bus.disp_addr = 12'h2AB;
        @(negedge clk);
        chk("t3_mem_addr", 32'(bus.mem_addr), 32'h1AB);
        chk("t3_mem_we", 32'(bus.mem_we), 32'd0);
        chk("t3_disp_gnt", 32'(bus.disp_gnt), 32'd1);
        tick();
        bus.disp_req = 1'b0;
        @(negedge clk);
        chk("t3_disp_rvalid", 32'(bus.disp_rvalid), 32'd1);
        tick();

        // CPU write followed by display read of the same byte
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 12'h110; bus.cpu_wdata = 8'h3C;
        @(negedge clk);
        chk("t4_mem_we", 32'(bus.mem_we), 32'd1);
        tick();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        bus.disp_req = 1'b1; bus.disp_addr = 12'h110;
        @(negedge clk);
        chk("t4_cpu_rvalid_after_write", 32'(bus.cpu_rvalid), 32'd0);
        tick();
        bus.disp_req = 1'b0;
        @(negedge clk);
        chk("t4_disp_rdata", 32'(bus.disp_rdata), 32'h3C);
        chk("t4_cpu_rdata", 32'(bus.cpu_rdata), 32'h00);
        tick();

        // Both request in the first cycle after reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h205;
        bus.disp_req = 1'b1; bus.disp_addr = 12'h1F0;
        @(negedge clk);
        chk("t5_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
        chk("t5_disp_gnt", 32'(bus.disp_gnt), 32'd0);
        tick();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("t5_disp_gnt_later", 32'(bus.disp_gnt), 32'd1);
        tick();
        bus.disp_req = 1'b0;
        tick();

        // Reset one cycle after a CPU read grant, with the counter part-way up
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
        bus.disp_req = 1'b1; bus.disp_addr = 12'h150;
        tick();
        tick();
        rst_n = 1'b0; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hEE;
        #1;
        chk("t6_mem_we_at_reset", 32'(bus.mem_we), 32'd0);
        chk("t6_gnt_at_reset", 32'({bus.cpu_gnt, bus.disp_gnt}), 32'd0);
        chk("t6_rvalid_at_reset", 32'(bus.cpu_rvalid), 32'd0);
        tick();
        rst_n = 1'b1; bus.cpu_we = 1'b0;
        record(5, seq);
        chk_seq("t6_seq_after_reset", seq, "CCCCD");
        bus.cpu_req = 1'b0; bus.disp_req = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
